// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game blocks.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAUSE,
    SHOW,
    OVER
  } state_t;

  localparam int TIMER_W  = 16;
  localparam int NUM_SEGS = 7;

  // Map the LFSR value onto 0..6 and never repeat the previous segment.
  function automatic logic [2:0] pick_seg(input logic [2:0] rnd, input logic [2:0] prev);
    logic [2:0] s;
    s = (rnd == 3'd7) ? 3'd0 : rnd;
    if (s == prev) begin
      s = (s == 3'(NUM_SEGS - 1)) ? 3'd0 : s + 3'd1;
    end
    return s;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: pulses for one cycle when d_i goes 0 -> 1.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: times pauses and mole visibility, tracks level,
// shrinking window, hits and misses, and flags game over.
module mole_scheduler
  import whack_pkg::*;
#(
  parameter logic [15:0] WIN_INIT       = 16'd50000,
  parameter logic [15:0] WIN_STEP       = 16'd5000,
  parameter logic [15:0] WIN_MIN        = 16'd10000,
  parameter logic [15:0] PAUSE_CYCLES   = 16'd20000,
  parameter int          HITS_PER_LEVEL = 4,
  parameter int          MAX_MISSES     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] rand_seg,
  input  logic       hit,
  output logic [2:0] mole_seg,
  output logic       mole_vis,
  output logic       new_mole,
  output logic [3:0] level,
  output logic [2:0] misses,
  output logic       game_over
);

  logic start_rise;

  rise_detect u_start_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (start),
    .rise_o (start_rise)
  );

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] window_q, window_d;
  logic [3:0]         hit_cnt_q, hit_cnt_d;
  logic [2:0]         mole_seg_q, mole_seg_d;
  logic               mole_vis_q, mole_vis_d;
  logic               new_mole_q, new_mole_d;
  logic [3:0]         level_q, level_d;
  logic [2:0]         misses_q, misses_d;
  logic               game_over_q, game_over_d;

  // One extra bit so the floor test cannot wrap for large parameters.
  logic [TIMER_W:0] win_floor_sum;
  assign win_floor_sum = {1'b0, WIN_MIN} + {1'b0, WIN_STEP};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      window_q    <= WIN_INIT;
      hit_cnt_q   <= '0;
      mole_seg_q  <= '0;
      mole_vis_q  <= 1'b0;
      new_mole_q  <= 1'b0;
      level_q     <= '0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      window_q    <= window_d;
      hit_cnt_q   <= hit_cnt_d;
      mole_seg_q  <= mole_seg_d;
      mole_vis_q  <= mole_vis_d;
      new_mole_q  <= new_mole_d;
      level_q     <= level_d;
      misses_q    <= misses_d;
      game_over_q <= game_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    window_d    = window_q;
    hit_cnt_d   = hit_cnt_q;
    mole_seg_d  = mole_seg_q;
    mole_vis_d  = mole_vis_q;
    new_mole_d  = 1'b0;
    level_d     = level_q;
    misses_d    = misses_q;
    game_over_d = game_over_q;

    // A restart overrides whatever the current state would do this cycle.
    if (start_rise) begin
      level_d     = '0;
      misses_d    = '0;
      hit_cnt_d   = '0;
      game_over_d = 1'b0;
      window_d    = WIN_INIT;
      timer_d     = PAUSE_CYCLES - 16'd1;
      mole_vis_d  = 1'b0;
      state_d     = PAUSE;
    end else begin
      case (state_q)
        PAUSE: begin
          mole_vis_d = 1'b0;
          if (timer_q == '0) begin
            mole_seg_d = pick_seg(rand_seg, mole_seg_q);
            mole_vis_d = 1'b1;
            new_mole_d = 1'b1;
            timer_d    = window_q - 16'd1;
            state_d    = SHOW;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        SHOW: begin
          if (hit) begin
            mole_vis_d = 1'b0;
            timer_d    = PAUSE_CYCLES - 16'd1;
            state_d    = PAUSE;
            if (hit_cnt_q == 4'(HITS_PER_LEVEL - 1)) begin
              hit_cnt_d = '0;
              if (level_q != 4'd15) begin
                level_d = level_q + 4'd1;
              end
              window_d = ({1'b0, window_q} < win_floor_sum) ? WIN_MIN : window_q - WIN_STEP;
            end else begin
              hit_cnt_d = hit_cnt_q + 4'd1;
            end
          end else if (timer_q == '0) begin
            misses_d   = misses_q + 3'd1;
            mole_vis_d = 1'b0;
            if (misses_q == 3'(MAX_MISSES - 1)) begin
              game_over_d = 1'b1;
              state_d     = OVER;
            end else begin
              timer_d = PAUSE_CYCLES - 16'd1;
              state_d = PAUSE;
            end
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        OVER: begin
          mole_vis_d  = 1'b0;
          game_over_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mole_seg  = mole_seg_q;
  assign mole_vis  = mole_vis_q;
  assign new_mole  = new_mole_q;
  assign level     = level_q;
  assign misses    = misses_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: per-mole vector table with a
// scoreboard queue, plus hand-written restart, reset and game-over sequences.
module tb_mole_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       hit;
  logic [2:0] rand_seg;
  logic [2:0] mole_seg;
  logic       mole_vis;
  logic       new_mole;
  logic [3:0] level;
  logic [2:0] misses;
  logic       game_over;

  localparam int PAUSE = 5;

  mole_scheduler #(
    .WIN_INIT       (16'd20),
    .WIN_STEP       (16'd4),
    .WIN_MIN        (16'd8),
    .PAUSE_CYCLES   (16'd5),
    .HITS_PER_LEVEL (2),
    .MAX_MISSES     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rand_seg  (rand_seg),
    .hit       (hit),
    .mole_seg  (mole_seg),
    .mole_vis  (mole_vis),
    .new_mole  (new_mole),
    .level     (level),
    .misses    (misses),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         restart;
    logic [2:0] rnd;
    int         hit_at;
    int         vis;
    logic [2:0] seg;
    logic [3:0] lvl;
    logic [2:0] mis;
    logic       go;
  } vec_t;

  typedef struct {
    int         blank;
    int         vis;
    int         nm;
    logic [2:0] seg;
    logic [3:0] lvl;
    logic [2:0] mis;
    logic       go;
  } exp_t;

  vec_t vecs[21];
  exp_t sb[$];

  function automatic vec_t mk(bit r, int rnd, int h, int seg, int vis, int lvl, int mis, int go);
    vec_t v;
    v.restart = r;
    v.rnd     = 3'(rnd);
    v.hit_at  = h;
    v.seg     = 3'(seg);
    v.vis     = vis;
    v.lvl     = 4'(lvl);
    v.mis     = 3'(mis);
    v.go      = go[0];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp_v);
    total++;
    if (got != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_vis(input string name);
    int n;
    n = 0;
    while (!mole_vis && n < 100) begin
      step();
      n++;
    end
    chk(name, mole_vis, 1);
  endtask

  // Counts blank cycles up to the mole, then visible cycles; optionally hits
  // on the hit_at-th visible cycle. Ends on the first sample after the mole.
  task automatic measure(input int hit_at, output int blank, output int vis,
                         output int nm, output logic [2:0] seg);
    blank = 0;
    vis   = 0;
    nm    = 0;
    seg   = '0;
    while (!mole_vis && blank < 200) begin
      blank++;
      if (new_mole) nm++;
      step();
    end
    seg = mole_seg;
    while (mole_vis && vis < 200) begin
      vis++;
      if (new_mole) nm++;
      if (vis == hit_at) hit = 1'b1;
      step();
      hit = 1'b0;
    end
    if (blank >= 200 || vis >= 200) begin
      total++;
      bad++;
      $display("FAIL measure_bound: blank=%0d vis=%0d required below 200", blank, vis);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t       v;
    exp_t       e;
    int         blank, vis, nm;
    logic [2:0] seg;
    v = vecs[i];
    rand_seg = v.rnd;
    if (v.restart) pulse_start();
    e.blank = PAUSE;
    e.vis   = v.vis;
    e.nm    = 1;
    e.seg   = v.seg;
    e.lvl   = v.lvl;
    e.mis   = v.mis;
    e.go    = v.go;
    sb.push_back(e);
    measure(v.hit_at, blank, vis, nm, seg);
    e = sb.pop_front();
    chk($sformatf("m%0d_blank", i), blank, e.blank);
    chk($sformatf("m%0d_vis", i), vis, e.vis);
    chk($sformatf("m%0d_new_mole", i), nm, e.nm);
    chk($sformatf("m%0d_seg", i), seg, e.seg);
    chk($sformatf("m%0d_level", i), level, e.lvl);
    chk($sformatf("m%0d_misses", i), misses, e.mis);
    chk($sformatf("m%0d_game_over", i), game_over, e.go);
    $display("mole %0d: seg=%0d blank=%0d vis=%0d level=%0d misses=%0d over=%0d",
             i, seg, blank, vis, level, misses, game_over);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mole_seg"}, mole_seg, 0);
    chk({tag, "_mole_vis"}, mole_vis, 0);
    chk({tag, "_new_mole"}, new_mole, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_misses"}, misses, 0);
    chk({tag, "_game_over"}, game_over, 0);
  endtask

  task automatic idle_run(input string name, input int cycles);
    int err;
    err = 0;
    for (int i = 0; i < cycles; i++) begin
      rand_seg = 3'($urandom_range(0, 7));
      hit      = (i % 17 == 3);
      step();
      if ({mole_seg, mole_vis, new_mole, level, misses, game_over} != '0) err++;
    end
    hit = 1'b0;
    chk(name, err, 0);
  endtask

  initial begin
    int err;

    // restart, rand, hit_at, seg, vis, level, misses, over
    vecs[0]  = mk(1, 3, 0, 3, 20, 0, 1, 0);
    vecs[1]  = mk(0, 7, 0, 0, 20, 0, 2, 0);
    vecs[2]  = mk(0, 7, 0, 1, 20, 0, 3, 1);
    vecs[3]  = mk(1, 6, 2, 6, 2, 0, 0, 0);
    vecs[4]  = mk(0, 6, 2, 0, 2, 1, 0, 0);
    vecs[5]  = mk(0, 2, 0, 2, 16, 1, 1, 0);
    vecs[6]  = mk(0, 4, 16, 4, 16, 1, 1, 0);
    vecs[7]  = mk(0, 5, 2, 5, 2, 2, 1, 0);
    vecs[8]  = mk(0, 1, 0, 1, 12, 2, 2, 0);
    vecs[9]  = mk(0, 3, 2, 3, 2, 2, 2, 0);
    vecs[10] = mk(0, 3, 2, 4, 2, 3, 2, 0);
    vecs[11] = mk(0, 0, 2, 0, 2, 3, 2, 0);
    vecs[12] = mk(0, 0, 2, 1, 2, 4, 2, 0);
    vecs[13] = mk(0, 2, 8, 2, 8, 4, 2, 0);
    vecs[14] = mk(0, 7, 0, 0, 8, 4, 3, 1);
    vecs[15] = mk(1, 5, 20, 5, 20, 0, 0, 0);
    vecs[16] = mk(0, 1, 3, 1, 3, 1, 0, 0);
    vecs[17] = mk(0, 2, 0, 2, 16, 1, 1, 0);
    vecs[18] = mk(1, 3, 2, 3, 2, 0, 0, 0);
    vecs[19] = mk(0, 4, 2, 4, 2, 1, 0, 0);
    vecs[20] = mk(0, 6, 0, 6, 20, 0, 1, 0);

    rst      = 1'b1;
    start    = 1'b0;
    hit      = 1'b0;
    rand_seg = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    idle_run("idle_200", 200);

    for (int i = 0; i <= 2; i++) run_vec(i);

    err = 0;
    for (int i = 0; i < 50; i++) begin
      hit      = (i == 10);
      rand_seg = 3'(i % 8);
      step();
      if (mole_vis || !game_over || misses != 3'd3 || new_mole) err++;
    end
    hit = 1'b0;
    chk("over_hold", err, 0);
    $display("over hold: misses=%0d over=%0d", misses, game_over);

    for (int i = 3; i <= 17; i++) run_vec(i);

    // Asynchronous reset in the middle of a visible mole.
    rand_seg = 3'd5;
    wait_vis("pre_rst_wait");
    chk("pre_rst_level", level, 1);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    $display("async reset: vis=%0d seg=%0d level=%0d", mole_vis, mole_seg, level);
    step();
    step();
    rst = 1'b0;
    idle_run("post_rst_idle", 50);

    for (int i = 18; i <= 19; i++) run_vec(i);

    // Restart during SHOW, coinciding with a hit: restart wins.
    rand_seg = 3'd1;
    wait_vis("restart_wait");
    step();
    start = 1'b1;
    hit   = 1'b1;
    step();
    start = 1'b0;
    hit   = 1'b0;
    chk("restart_vis", mole_vis, 0);
    chk("restart_level", level, 0);
    chk("restart_misses", misses, 0);
    chk("restart_game_over", game_over, 0);
    $display("restart in show: vis=%0d level=%0d misses=%0d", mole_vis, level, misses);

    run_vec(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Round sequencer for the whack-a-mole game. Decides when a mole appears, which segment it occupies, and how long it stays lit. Shrinks the visibility window as the player levels up, counts misses, and declares game over after a fixed number of misses. It sits between the LFSR segment source and the game FSM / 7-segment driver. It consumes the FSM's hit pulse and drives the mole position and visibility that the display path shows.

## Interface
Parameters:
- WIN_INIT, 16'd50000: initial mole visibility window, in cycles (≥ WIN_MIN).
- WIN_STEP, 16'd5000: window reduction per level-up.
- WIN_MIN, 16'd10000: window floor (≥ 1).
- PAUSE_CYCLES, 16'd20000: blank gap between moles (≥ 1).
- HITS_PER_LEVEL, 4: hits needed per level-up (1..15).
- MAX_MISSES, 3: timeouts that end the game (1..7).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  debounced start button (level); acted on at its rising edge, detected internally.
- rand_seg  in  3  random segment from the LFSR.
- hit  in  1  one-cycle pulse: the correct button was pressed.
- mole_seg  out  3  current mole segment, 0..6.
- mole_vis  out  1  mole lit.
- new_mole  out  1  one-cycle pulse on the first visible cycle of each mole.
- level  out  4  current level, saturates at 15.
- misses  out  3  timeouts this game.
- game_over  out  1  game ended.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE; all outputs 0.
  - window = WIN_INIT; internal timer and hit counter 0.
- States: IDLE, PAUSE, SHOW, OVER.
- Start rising edge in any state:
  - clears level, misses, hit counter and game_over.
  - sets window = WIN_INIT and timer = PAUSE_CYCLES-1.
  - mole_vis = 0; next state PAUSE.
- PAUSE:
  - mole_vis = 0; timer decrements.
  - At timer == 0 the mole segment is chosen as follows:
    - s = (rand_seg == 7) ? 0 : rand_seg.
    - If s equals the previous mole_seg, use (s+1) mod 7 instead.
  - At that same edge: mole_vis = 1, new_mole = 1, timer = window-1, next state SHOW.
- SHOW, hit == 1:
  - hit counter +1, mole_vis = 0, timer = PAUSE_CYCLES-1, next state PAUSE.
  - When the counter reaches HITS_PER_LEVEL it clears and the player levels up:
    - level +1, saturating at 15.
    - window = (window < WIN_MIN+WIN_STEP) ? WIN_MIN : window-WIN_STEP. No underflow.
- SHOW, timer == 0 and no hit:
  - misses +1, mole_vis = 0.
  - If misses reaches MAX_MISSES: next state OVER.
  - Otherwise: timer = PAUSE_CYCLES-1, next state PAUSE.
- Hit and timeout in the same cycle: the hit wins and misses is unchanged.
- hit outside SHOW is ignored.
- OVER: game_over = 1, mole_vis = 0. The state holds until a start rising edge.
- Start edge together with hit or timeout: the restart wins.

## Timing
- Each mole is visible exactly window cycles when not hit.
- Each gap is exactly PAUSE_CYCLES cycles with mole_vis = 0.
- mole_seg, mole_vis and new_mole change on the same edge. new_mole lasts one cycle.
- hit sampled at edge t: mole_vis = 0 from edge t onward (one-cycle response). level, window and misses update at that same edge.
- Start rising edge at edge t: PAUSE begins at t. The first mole appears PAUSE_CYCLES cycles later.
- rst is asynchronous: asserting it mid-SHOW clears all outputs immediately, without a clock edge.
- Release is synchronised outside the block.

## Structure
- Shared package whack_pkg holds:
  - the state enum (IDLE, PAUSE, SHOW, OVER);
  - the timer width constant (16);
  - the segment count constant (7).
- One sub-module: rise_detect, a registered rising-edge detector for start. It is reusable by the game FSM.
- The remainder is a single FSM with timer, window, hit-counter and miss-counter registers.

## Test plan
All scenarios use WIN_INIT=20, WIN_STEP=4, WIN_MIN=8, PAUSE_CYCLES=5, HITS_PER_LEVEL=2, MAX_MISSES=3.
- Reset with start held low for 200 cycles -> every output stays 0.
- Start pulse, no hits -> cycle repeats 5 blank / 20 visible three times. After the third timeout: misses=3, game_over=1, mole_vis=0, and the state holds.
- Hit on the 2nd visible cycle of every mole -> level 1 with window 16 after 2 hits, then window 12, then 8. Window stays 8 at level 4+. mole_vis drops at the edge after each hit.
- rand_seg forced to 7 -> mole_seg=0. Forced to 6 twice in a row -> mole_seg 6 then 0. new_mole pulses once per mole.
- hit asserted on the 20th (last) visible cycle -> counted as a hit, misses unchanged. Start edge during SHOW -> counters cleared, 5-cycle pause begins.
- rst raised mid-SHOW between clock edges -> all outputs 0 immediately. After release with no start, the block stays IDLE.
